// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between N_REQ byte requesters.
// Round-robin grant with a burst lock of up to MAX_BURST back-to-back bytes.
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int D_BITS    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                    i_clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*D_BITS-1:0] i_req_data,
    output logic [N_REQ-1:0]        o_ack,
    output logic [N_REQ-1:0]        o_done,
    output logic                    o_busy,
    output logic [D_BITS-1:0]       o_tx_data,
    output logic                    o_tx_enable,
    input  logic                    i_tx_rdy,
    input  logic                    i_tx_done
);
    localparam int IW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam logic [BW-1:0] BLAST = BW'(MAX_BURST - 1);
    localparam logic [IW-1:0] ILAST = IW'(N_REQ - 1);

    typedef enum logic [1:0] {ARB, ISSUE, WAIT} state_e;

    state_e            state_q;
    logic [IW-1:0]     rr_ptr_q;
    logic [IW-1:0]     owner_q;
    logic [BW-1:0]     burst_cnt_q;
    logic [N_REQ-1:0]  ack_q;
    logic              busy_q;
    logic              en_q;
    logic [D_BITS-1:0] data_q;

    logic [IW-1:0] owner_nxt;
    logic [IW-1:0] base;
    logic [IW-1:0] grant;
    logic [IW-1:0] idx;
    logic          keep;
    logic          drop;
    logic          found;

    assign owner_nxt = (owner_q == ILAST) ? '0 : owner_q + IW'(1);

    // The burst owner keeps priority only while it is still requesting.
    assign keep = (burst_cnt_q != '0) && i_req[owner_q];
    assign drop = (burst_cnt_q != '0) && !i_req[owner_q];
    assign base = drop ? owner_nxt : rr_ptr_q;

    always_comb begin
        grant = owner_q;
        found = keep;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = IW'((int'(base) + i) % N_REQ);
            if (!found && i_req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ARB;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            ack_q       <= '0;
            busy_q      <= 1'b0;
            en_q        <= 1'b0;
            data_q      <= '0;
        end else begin
            ack_q <= '0;
            en_q  <= 1'b0;
            unique case (state_q)
                ARB: begin
                    if (drop) begin
                        burst_cnt_q <= '0;
                        rr_ptr_q    <= owner_nxt;
                    end
                    if (i_tx_rdy && |i_req) begin
                        data_q  <= i_req_data[grant*D_BITS +: D_BITS];
                        owner_q <= grant;
                        ack_q   <= N_REQ'(1) << grant;
                        en_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: state_q <= WAIT;
                WAIT: begin
                    if (i_tx_done) begin
                        busy_q  <= 1'b0;
                        state_q <= ARB;
                        if (burst_cnt_q == BLAST) begin
                            burst_cnt_q <= '0;
                            rr_ptr_q    <= owner_nxt;
                        end else begin
                            burst_cnt_q <= burst_cnt_q + BW'(1);
                        end
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign o_ack       = ack_q;
    assign o_busy      = busy_q;
    assign o_tx_enable = en_q;
    assign o_tx_data   = data_q;
    assign o_done      = (state_q == WAIT && i_tx_done)
                       ? (N_REQ'(1) << owner_q) : '0;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter.
// A transaction-level model predicts grants; a monitor checks the DUT.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int DB = 8;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    i_req;
    logic [N*DB-1:0] i_req_data;
    logic [N-1:0]    o_ack;
    logic [N-1:0]    o_done;
    logic            o_busy;
    logic [DB-1:0]   o_tx_data;
    logic            o_tx_enable;
    logic            i_tx_rdy;
    logic            i_tx_done;

    uart_tx_arbiter #(.N_REQ(N), .D_BITS(DB), .MAX_BURST(MB)) dut (
        .i_clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_req_data(i_req_data),
        .o_ack(o_ack), .o_done(o_done), .o_busy(o_busy),
        .o_tx_data(o_tx_data), .o_tx_enable(o_tx_enable),
        .i_tx_rdy(i_tx_rdy), .i_tx_done(i_tx_done)
    );

    always #5 clk = ~clk;

    typedef struct { int idx; int data; } xfer_t;

    int    checks = 0;
    int    errors = 0;
    xfer_t exp_ack[$];
    int    exp_done[$];
    int    sent_log[$];
    int    done_log[$];

    bit m_busy, m_issue;
    int m_ptr, m_cnt, m_owner, m_g;

    int           rq[N][$];
    int           gap[N];
    int           gap_max    = 0;
    int           fmax       = 5;
    int           spur_cnt   = 0;
    bit           force_busy = 1'b0;
    logic [N-1:0] ack_seen;

    function automatic int idx_of(logic [N-1:0] v);
        int r = -1;
        for (int k = 0; k < N; k++) if (v[k] && r < 0) r = k;
        return r;
    endfunction

    // Reference model: one transaction at a time, round robin with burst lock.
    initial begin : model
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                m_busy = 0; m_issue = 0; m_ptr = 0; m_cnt = 0; m_owner = 0;
                exp_ack.delete();
                exp_done.delete();
            end else if (m_busy) begin
                if (m_issue) m_issue = 0;
                else if (i_tx_done) begin
                    m_busy = 0;
                    m_cnt++;
                    if (m_cnt == MB) begin
                        m_cnt = 0;
                        m_ptr = (m_owner + 1) % N;
                    end
                end
            end else begin
                if (m_cnt > 0 && !i_req[m_owner]) begin
                    m_cnt = 0;
                    m_ptr = (m_owner + 1) % N;
                end
                if (i_tx_rdy && i_req != 0) begin
                    m_g = (m_cnt > 0) ? m_owner : -1;
                    for (int i = 0; i < N; i++)
                        if (m_g < 0 && i_req[(m_ptr + i) % N]) m_g = (m_ptr + i) % N;
                    exp_ack.push_back('{m_g, int'(i_req_data[m_g*DB +: DB])});
                    exp_done.push_back(m_g);
                    m_owner = m_g;
                    m_busy  = 1;
                    m_issue = 1;
                end
            end
        end
    end

    initial begin : monitor
        xfer_t e;
        int    d;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                checks++;
                if (o_busy !== m_busy) begin
                    errors++;
                    $display("FAIL busy: got %b want %b", o_busy, m_busy);
                end
                checks++;
                if (exp_ack.size() > 0) begin
                    e = exp_ack.pop_front();
                    if (o_ack !== (N'(1) << e.idx) || o_tx_enable !== 1'b1 ||
                        o_tx_data !== DB'(e.data)) begin
                        errors++;
                        $display("FAIL grant: got ack %b en %b data %h want ack %b data %h",
                                 o_ack, o_tx_enable, o_tx_data, N'(1) << e.idx, DB'(e.data));
                    end
                    sent_log.push_back(idx_of(o_ack) * 256 + int'(o_tx_data));
                end else if (o_ack !== '0 || o_tx_enable !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_grant: got ack %b en %b want 0 0", o_ack, o_tx_enable);
                end
                checks++;
                if (m_busy && !m_issue && i_tx_done) begin
                    d = (exp_done.size() > 0) ? exp_done.pop_front() : -1;
                    if (o_done !== (N'(1) << d)) begin
                        errors++;
                        $display("FAIL done: got %b want %b", o_done, N'(1) << d);
                    end
                    done_log.push_back(idx_of(o_done));
                end else if (o_done !== '0) begin
                    errors++;
                    $display("FAIL spurious_done: got %b want 0", o_done);
                end
            end
        end
    end

    // Transmitter stand-in: frame of random length after each enable pulse.
    initial begin : txm
        bit en, busy;
        int cnt, spur_seen;
        busy = 0; cnt = 0; spur_seen = 0;
        i_tx_rdy = 1'b1;
        i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            en = o_tx_enable;
            @(posedge clk);
            #1;
            i_tx_done = 1'b0;
            if (!reset_n) begin
                busy = 0;
                spur_seen = spur_cnt;
            end else begin
                if (busy) begin
                    cnt--;
                    if (cnt == 0) begin
                        busy = 0;
                        i_tx_done = 1'b1;
                    end
                end else if (spur_seen != spur_cnt && !en) begin
                    spur_seen++;
                    i_tx_done = 1'b1;
                end
                if (en) begin
                    busy = 1;
                    cnt = $urandom_range(2, fmax);
                end
            end
            i_tx_rdy = !busy && !force_busy;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(negedge clk);
        ack_seen = o_ack;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (i_req[k] && ack_seen[k]) begin
                i_req[k] = 1'b0;
                gap[k] = $urandom_range(0, gap_max);
            end
            if (!i_req[k] && rq[k].size() > 0 && reset_n) begin
                if (gap[k] > 0) gap[k]--;
                else begin
                    i_req_data[k*DB +: DB] = DB'(rq[k].pop_front());
                    i_req[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    function automatic bit pending();
        bit p = 0;
        for (int k = 0; k < N; k++) if (rq[k].size() > 0) p = 1;
        return p;
    endfunction

    task automatic expect_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        while ((pending() || m_busy || i_req != 0) && n < limit) begin
            cycle();
            n++;
        end
        run(3);
        expect_eq({name, "_timeout"}, int'(n >= limit), 0);
    endtask

    task automatic expect_seq(input string name, input int base, input int exp[$]);
        expect_eq({name, "_len"}, sent_log.size() - base, exp.size());
        for (int i = 0; i < exp.size(); i++)
            if (base + i < sent_log.size()) begin
                checks++;
                if (sent_log[base + i] != exp[i]) begin
                    errors++;
                    $display("FAIL %s[%0d]: got %0h want %0h",
                             name, i, sent_log[base + i], exp[i]);
                end
            end
    endtask

    initial begin : main
        int base, dbase, n;
        int e[$];
        reset_n = 1'b0;
        i_req = '0;
        i_req_data = '0;
        for (int k = 0; k < N; k++) gap[k] = 0;
        repeat (2) @(posedge clk);
        #1;
        expect_eq("rst_ack", int'(o_ack), 0);
        expect_eq("rst_done", int'(o_done), 0);
        expect_eq("rst_busy", int'(o_busy), 0);
        expect_eq("rst_en", int'(o_tx_enable), 0);
        expect_eq("rst_data", int'(o_tx_data), 0);
        reset_n = 1'b1;
        run(2);

        base = sent_log.size();
        dbase = done_log.size();
        rq[2].push_back('hA5);
        drain("single", 100);
        e = '{2*256 + 'hA5};
        expect_seq("single", base, e);
        expect_eq("single_done", (done_log.size() > dbase) ? done_log[dbase] : -1, 2);

        base = sent_log.size();
        for (int k = 0; k < N; k++) begin
            rq[k].push_back('h10 + k*'h11);
            rq[k].push_back('h10 + k*'h11);
        end
        drain("rr", 300);
        e = '{3*256+'h43, 3*256+'h43, 'h10, 'h10,
              256+'h21, 256+'h21, 2*256+'h32, 2*256+'h32};
        expect_seq("rr", base, e);

        base = sent_log.size();
        for (int i = 0; i < 6; i++) rq[1].push_back('h60 + i);
        run(2);
        rq[3].push_back('h70);
        drain("burst", 300);
        e = '{256+'h60, 256+'h61, 256+'h62, 256+'h63,
              3*256+'h70, 256+'h64, 256+'h65};
        expect_seq("burst", base, e);

        force_busy = 1'b1;
        run(2);
        base = sent_log.size();
        i_req_data[DB-1:0] = 8'h55;
        i_req[0] = 1'b1;
        run(1);
        i_req[0] = 1'b0;
        run(2);
        force_busy = 1'b0;
        run(4);
        expect_eq("withdraw", sent_log.size() - base, 0);
        dbase = done_log.size();
        rq[0].push_back('h5A);
        drain("late_drop", 100);
        e = '{'h5A};
        expect_seq("late_drop", base, e);
        expect_eq("late_drop_done", (done_log.size() > dbase) ? done_log[dbase] : -1, 0);

        base = sent_log.size();
        dbase = done_log.size();
        spur_cnt++;
        run(4);
        expect_eq("spur_done", done_log.size() - dbase, 0);
        expect_eq("spur_sent", sent_log.size() - base, 0);

        fmax = 20;
        rq[2].push_back('h33);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(o_busy && !o_tx_enable) && n < 50);
        expect_eq("reach_wait", int'(n >= 50), 0);
        #2;
        reset_n = 1'b0;
        #1;
        expect_eq("arst_ack", int'(o_ack), 0);
        expect_eq("arst_done", int'(o_done), 0);
        expect_eq("arst_busy", int'(o_busy), 0);
        expect_eq("arst_en", int'(o_tx_enable), 0);
        expect_eq("arst_data", int'(o_tx_data), 0);
        for (int k = 0; k < N; k++) rq[k].push_back('h80 + k);
        run(2);
        reset_n = 1'b1;
        base = sent_log.size();
        dbase = done_log.size();
        drain("after_rst", 300);
        e = '{'h80, 256+'h81, 2*256+'h82, 3*256+'h83};
        expect_seq("after_rst", base, e);
        expect_eq("after_rst_done", done_log.size() - dbase, 4);

        fmax = 6;
        gap_max = 3;
        for (int it = 0; it < 80; it++) begin
            repeat ($urandom_range(0, 2)) rq[$urandom_range(0, N-1)].push_back($urandom_range(0, 255));
            force_busy = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) spur_cnt++;
            run($urandom_range(0, 5));
        end
        force_busy = 1'b0;
        drain("random", 5000);
        expect_eq("left_done", exp_done.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
